// File: rtl/byte_stats_pkg.sv
// Shared byte-statistics definitions: widths, accumulator FSM states, popcount helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package byte_stats_pkg;

  localparam int BYTE_W = 8;
  localparam int POP_W  = 4;   // 0..8 needs four bits; three would wrap 0xFF to 0

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Count set bits of one byte.
  function automatic logic [POP_W-1:0] popcount8(input logic [BYTE_W-1:0] b);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      cnt = cnt + POP_W'(b[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/byte_popcount.sv
// Combinational ones-count of one byte (0..8).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; no handshake, result follows the input.
module byte_popcount
  import byte_stats_pkg::*;
(
  input  logic [BYTE_W-1:0] data_i,
  output logic [POP_W-1:0]  ones_o
);

  // Single adder-tree reduction of the byte.
  always_comb begin
    ones_o = popcount8(data_i);
  end

endmodule

// File: rtl/byte_ones_accumulator.sv
// Per-frame ones total, byte count, parity and overflow over a byte stream.
// Latency: result valid 1 cycle after the last beat of a frame is accepted.
// Backpressure: in_ready drops while a result is held; released the cycle after out_ready takes it.
module byte_ones_accumulator
  import byte_stats_pkg::*;
#(
  parameter  int LEN_W = 8,
  localparam int SUM_W = LEN_W + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_ones,
  output logic [LEN_W-1:0]  out_bytes,
  output logic              out_parity,
  output logic              out_overflow
);

  localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   acc_ones_q, acc_ones_d;
  logic [LEN_W-1:0]   acc_bytes_q, acc_bytes_d;
  logic               acc_ovf_q, acc_ovf_d;
  logic [SUM_W-1:0]   res_ones_q, res_ones_d;
  logic [LEN_W-1:0]   res_bytes_q, res_bytes_d;
  logic               res_ovf_q, res_ovf_d;

  logic [POP_W-1:0]   pop;
  logic               accept;
  logic               at_max;
  logic [SUM_W-1:0]   ones_next;
  logic [LEN_W-1:0]   bytes_next;
  logic               ovf_next;

  byte_popcount u_popcount (
    .data_i (in_byte),
    .ones_o (pop)
  );

  // Accept only in ACCUM; once the counter is pinned at its maximum, further
  // bytes neither count nor contribute ones, they only mark the frame overflowed.
  always_comb begin
    accept     = in_valid && (state_q == ACCUM);
    at_max     = (acc_bytes_q == CNT_MAX);
    ones_next  = at_max ? acc_ones_q  : acc_ones_q + SUM_W'(pop);
    bytes_next = at_max ? acc_bytes_q : acc_bytes_q + LEN_W'(1);
    ovf_next   = acc_ovf_q | at_max;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; no bypass from HOLD straight to accepting.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && in_last) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Accumulator and result next-state: last beat folds into the result and clears the running sums.
  always_comb begin
    acc_ones_d  = acc_ones_q;
    acc_bytes_d = acc_bytes_q;
    acc_ovf_d   = acc_ovf_q;
    res_ones_d  = res_ones_q;
    res_bytes_d = res_bytes_q;
    res_ovf_d   = res_ovf_q;
    if (accept) begin
      if (in_last) begin
        res_ones_d  = ones_next;
        res_bytes_d = bytes_next;
        res_ovf_d   = ovf_next;
        acc_ones_d  = '0;
        acc_bytes_d = '0;
        acc_ovf_d   = 1'b0;
      end else begin
        acc_ones_d  = ones_next;
        acc_bytes_d = bytes_next;
        acc_ovf_d   = ovf_next;
      end
    end
  end

  // Datapath registers; result registers only change on a last beat so they stay stable in HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_ones_q  <= '0;
      acc_bytes_q <= '0;
      acc_ovf_q   <= 1'b0;
      res_ones_q  <= '0;
      res_bytes_q <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      acc_ones_q  <= acc_ones_d;
      acc_bytes_q <= acc_bytes_d;
      acc_ovf_q   <= acc_ovf_d;
      res_ones_q  <= res_ones_d;
      res_bytes_q <= res_bytes_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  // Parity of all counted bits is the LSB of their sum.
  always_comb begin
    out_ones     = res_ones_q;
    out_bytes    = res_bytes_q;
    out_parity   = res_ones_q[0];
    out_overflow = res_ovf_q;
  end

endmodule

// File: tb/tb_byte_ones_accumulator.sv
module tb_byte_ones_accumulator;

  typedef struct {
    int o8; int b8; bit v8;
    int o2; int b2; bit v2;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        out_ready;
  logic        out_ready_dir;
  logic        out_ready_rnd;
  logic        rand_mode;

  logic        rdy8, ov8, par8, ovf8;
  logic [10:0] ones8;
  logic [7:0]  bytes8;
  logic        rdy2, ov2, par2, ovf2;
  logic [4:0]  ones2;
  logic [1:0]  bytes2;

  int checks = 0;
  int failures = 0;
  int frames_sent = 0;
  int n_results = 0;
  res_t exp_q[$];
  logic [7:0] fr [20];

  assign out_ready = rand_mode ? out_ready_rnd : out_ready_dir;

  always #5 clk = ~clk;

  byte_ones_accumulator #(.LEN_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy8),
    .in_byte(in_byte), .in_last(in_last), .out_valid(ov8), .out_ready(out_ready),
    .out_ones(ones8), .out_bytes(bytes8), .out_parity(par8), .out_overflow(ovf8)
  );

  byte_ones_accumulator #(.LEN_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
    .in_byte(in_byte), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
    .out_ones(ones2), .out_bytes(bytes2), .out_parity(par2), .out_overflow(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: bytes beyond the counter maximum are dropped from both sums and flag overflow.
  function automatic void model(input int len, input int maxlen, output int ones,
                                output int nb, output bit ovf);
    int kept;
    kept = (len > maxlen) ? maxlen : len;
    ones = 0;
    for (int i = 0; i < kept; i++) ones += $countones(fr[i]);
    nb  = kept;
    ovf = (len > maxlen);
  endfunction

  task automatic push_exp(input int o8, input int b8, input bit v8,
                          input int o2, input int b2, input bit v2);
    res_t r;
    r.o8 = o8; r.b8 = b8; r.v8 = v8;
    r.o2 = o2; r.b2 = b2; r.v2 = v2;
    exp_q.push_back(r);
    frames_sent++;
  endtask

  // Present one beat (after optional idle gap) and hold it until accepted.
  task automatic send_beat(input logic [7:0] b, input logic last, input int gap);
    int waited;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_byte = b; in_last = last;
    waited = 0;
    forever begin
      @(negedge clk);
      if (rdy8) break;
      waited++;
      if (waited > 100) begin
        check("beat_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  // Out-ready randomiser, only used when rand_mode is set.
  initial begin
    out_ready_rnd = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready_rnd = ($urandom_range(0, 3) != 0);
    end
  end

  // Result monitor: a result is taken on the edge after a negedge with out_valid & out_ready.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (!reset && ov8 && out_ready) begin
        n_results++;
        check("valid_lockstep", ov2, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ones8", ones8, e.o8);
          check("bytes8", bytes8, e.b8);
          check("parity8", par8, e.o8 & 1);
          check("ovf8", ovf8, e.v8);
          check("ones2", ones2, e.o2);
          check("bytes2", bytes2, e.b2);
          check("parity2", par2, e.o2 & 1);
          check("ovf2", ovf2, e.v2);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, gap, o8, b8, o2, b2;
    bit v8, v2;
    reset = 1'b1; in_valid = 1'b0; in_byte = '0; in_last = 1'b0;
    out_ready_dir = 1'b1; rand_mode = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check("rst_valid", ov8, 0);
    check("rst_ones", ones8, 0);
    check("rst_bytes", bytes8, 0);
    check("rst_parity", par8, 0);
    check("rst_ovf", ovf8, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", rdy8, 1);

    // Frame FF 00 0F 81: 1-cycle latency
    push_exp(14, 4, 0, 12, 3, 1);
    send_beat(8'hFF, 0, 0);
    send_beat(8'h00, 0, 0);
    send_beat(8'h0F, 0, 0);
    check("t1_valid_before", ov8, 0);
    send_beat(8'h81, 1, 0);
    @(negedge clk);
    check("t1_valid_latency", ov8, 1);
    @(posedge clk); #1;
    wait_drain();

    // Single-byte frames, no carry-over
    push_exp(8, 1, 0, 8, 1, 0);
    send_beat(8'hFF, 1, 0);
    push_exp(1, 1, 0, 1, 1, 0);
    send_beat(8'h01, 1, 0);
    wait_drain();

    // Backpressure with a beat waiting
    out_ready_dir = 1'b0;
    push_exp(5, 2, 0, 5, 2, 0);
    send_beat(8'h03, 0, 0);
    send_beat(8'h07, 1, 0);
    in_valid = 1'b1; in_byte = 8'h3F; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", ov8, 1);
      check("bp_in_ready", rdy8, 0);
      check("bp_ones", ones8, 5);
      check("bp_bytes", bytes8, 2);
    end
    @(posedge clk); #1;
    out_ready_dir = 1'b1;
    check("bp_no_bypass", rdy8, 0);
    @(posedge clk); #1;
    check("bp_release_ready", rdy8, 1);
    push_exp(6, 1, 0, 6, 1, 0);
    send_beat(8'h3F, 1, 0);
    wait_drain();

    // Overflow on narrow counter, then a clean frame
    push_exp(40, 5, 0, 24, 3, 1);
    for (int i = 0; i < 5; i++) send_beat(8'hFF, i == 4, 0);
    push_exp(1, 1, 0, 1, 1, 0);
    send_beat(8'h01, 1, 0);
    wait_drain();

    // Reset mid-frame discards partial sums
    send_beat(8'hFF, 0, 0);
    send_beat(8'hFF, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    push_exp(4, 1, 0, 4, 1, 0);
    send_beat(8'h0F, 1, 0);
    wait_drain();

    // Reset in HOLD discards the pending result
    out_ready_dir = 1'b0;
    send_beat(8'h55, 1, 0);
    @(negedge clk);
    check("hold_valid", ov8, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready_dir = 1'b1;
    @(negedge clk);
    check("hold_rst_valid", ov8, 0);
    check("hold_rst_ready", rdy8, 1);
    @(posedge clk); #1;

    // Randomised frames
    rand_mode = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) fr[i] = 8'($urandom);
      model(len, 255, o8, b8, v8);
      model(len, 3, o2, b2, v2);
      push_exp(o8, b8, v8, o2, b2, v2);
      for (int i = 0; i < len; i++) begin
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        send_beat(fr[i], i == len - 1, gap);
      end
    end
    wait_drain();
    check("result_count", n_results, frames_sent);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
